// File: rtl/matmul_job_scheduler.sv
// Round-robin job scheduler sharing one matrix-multiplier datapath between NUM_REQ requesters.
// Optional watchdog abort enabled by defining MATMUL_SCHED_TIMEOUT_EN.
module matmul_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DIM_W          = 8,
  parameter int IN_MEM_SIZE    = 64,
  parameter int OUT_MEM_SIZE   = 16,
  parameter int PAR_JOBS       = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*4*DIM_W-1:0]     req_dims_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           resp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]     resp_id_o,
  output logic                           resp_err_o,
  output logic                           busy_o,
  output logic [$clog2(NUM_REQ)-1:0]     mm_owner_o,
  output logic [4*32-1:0]                mm_cfg_o,
  output logic                           mm_reset_o,
  output logic                           mm_enable_o,
  input  logic                           mm_done_i
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = 2*DIM_W + 1;
  localparam int JW  = 4*DIM_W;

  if (NUM_REQ < 2 || NUM_REQ > 8 || PAR_JOBS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("matmul_job_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REJECT, S_CLEAR, S_START, S_RUN, S_FINISH, S_ABORT
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   owner_q, last_q, resp_id_q;
  logic [JW-1:0]    dims_q;
  logic             cfg_hold_q, resp_valid_q, resp_err_q, mm_reset_q, mm_enable_q;

`ifdef MATMUL_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q;
  logic          to_hit;
  assign to_hit = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Per-requester view of the flat dimension bus.
  logic [JW-1:0] dims_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dims
    assign dims_arr[g] = req_dims_i[g*JW +: JW];
  end

  // Round-robin search starting just above the last served requester.
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx, cand;
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Products sized so the worst case of every term fits without wrap.
  logic [DIM_W-1:0] wa, ha, wb, hb;
  logic [PW-1:0]    need_in, need_out;
  logic             job_ok;
  assign {hb, wb, ha, wa} = dims_q;
  assign need_in  = PW'(6) + PW'(wa) * PW'(ha) + PW'(wb) * PW'(hb);
  assign need_out = PW'(wa) * PW'(hb);
  assign job_ok   = (wa != '0) && (ha != '0) && (wb != '0) && (hb != '0) &&
                    ((wa % DIM_W'(PAR_JOBS)) == '0) &&
                    (32'(need_in)  <= 32'(IN_MEM_SIZE)) &&
                    (32'(need_out) <= 32'(OUT_MEM_SIZE));

  logic cfg_on;
  assign cfg_on = cfg_hold_q | ((state_q == S_CHECK) & job_ok);
  for (genvar k = 0; k < 4; k++) begin : g_cfg
    assign mm_cfg_o[32*k +: 32] = cfg_on ? 32'(dims_q[DIM_W*k +: DIM_W]) : 32'd0;
  end

  assign req_ready_o  = (!reset && state_q == S_IDLE && gnt_found) ?
                        (NUM_REQ'(1) << gnt_idx) : '0;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_id_o    = resp_id_q;
  assign busy_o       = (state_q != S_IDLE);
  assign mm_owner_o   = owner_q;
  assign mm_reset_o   = mm_reset_q;
  assign mm_enable_o  = mm_enable_q;

  // Outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_q       <= IDW'(NUM_REQ - 1);
      resp_id_q    <= '0;
      dims_q       <= '0;
      cfg_hold_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mm_reset_q   <= 1'b0;
      mm_enable_q  <= 1'b0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_id_q    <= '0;
      mm_reset_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (gnt_found) begin
          dims_q     <= dims_arr[gnt_idx];
          owner_q    <= gnt_idx;
          cfg_hold_q <= 1'b0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
          cnt_q      <= '0;
`endif
          state_q    <= S_CHECK;
        end
        S_CHECK: if (job_ok) begin
          cfg_hold_q <= 1'b1;
          mm_reset_q <= 1'b1;
          state_q    <= S_CLEAR;
        end else begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_id_q    <= owner_q;
          state_q      <= S_REJECT;
        end
        S_REJECT: begin
          last_q  <= owner_q;
          state_q <= S_IDLE;
        end
        S_CLEAR: begin
          mm_enable_q <= 1'b1;
          state_q     <= S_START;
        end
        S_START: begin
          if (!mm_done_i) state_q <= S_RUN;
`ifdef MATMUL_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            mm_enable_q <= 1'b0;
            mm_reset_q  <= 1'b1;
            state_q     <= S_ABORT;
          end
          cnt_q <= cnt_q + 1'b1;
`endif
        end
        S_RUN: begin
          if (mm_done_i) begin
            mm_enable_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_id_q    <= owner_q;
            state_q      <= S_FINISH;
          end
`ifdef MATMUL_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            mm_enable_q <= 1'b0;
            mm_reset_q  <= 1'b1;
            state_q     <= S_ABORT;
          end
          cnt_q <= cnt_q + 1'b1;
`endif
        end
        S_FINISH: begin
          last_q  <= owner_q;
          state_q <= S_IDLE;
        end
        S_ABORT: begin
          // Multiplier has just been reset; report the abort like a reject.
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_id_q    <= owner_q;
          state_q      <= S_REJECT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Scoreboard bench for matmul_job_scheduler: random and directed jobs against a rule-level model.
module tb_matmul_job_scheduler;
  localparam int NR = 4;
  localparam int JW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR*JW-1:0] req_dims  = '0;
  logic [NR-1:0]    req_ready_o;
  logic             resp_valid_o, resp_err_o, busy_o, mm_reset_o, mm_enable_o;
  logic [1:0]       resp_id_o, mm_owner_o;
  logic [127:0]     mm_cfg_o;
  logic             mm_done = 1'b1;

  matmul_job_scheduler #(
    .NUM_REQ(NR), .DIM_W(8), .IN_MEM_SIZE(32), .OUT_MEM_SIZE(16),
    .PAR_JOBS(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_dims_i(req_dims),
    .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o),
    .resp_err_o(resp_err_o), .busy_o(busy_o), .mm_owner_o(mm_owner_o),
    .mm_cfg_o(mm_cfg_o), .mm_reset_o(mm_reset_o), .mm_enable_o(mm_enable_o),
    .mm_done_i(mm_done)
  );

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Multiplier stand-in: idle reports done, runs mrun cycles once enabled, or sticks at done.
  int mrun = 3, mrun_force = 0, mcnt = 0, mst = 0;
  bit stuck = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset || mm_reset_o) begin
      mst <= 0; mm_done <= 1'b1;
    end else if (stuck) mm_done <= 1'b1;
    else if (mst == 0) begin
      if (mm_enable_o) begin mst <= 1; mcnt <= mrun; mm_done <= 1'b0; end
    end else if (mst == 1) begin
      if (mcnt <= 1) begin mst <= 2; mm_done <= 1'b1; end
      else mcnt <= mcnt - 1;
    end
  end

  function automatic bit bad(input logic [31:0] d);
    int wa, ha, wb, hb;
    wa = d[7:0]; ha = d[15:8]; wb = d[23:16]; hb = d[31:24];
    return wa == 0 || ha == 0 || wb == 0 || hb == 0 || (wa % 2) != 0 ||
           6 + wa*ha + wb*hb > 32 || wa*hb > 16;
  endfunction

  function automatic logic [127:0] exp_cfg(input logic [31:0] d);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = {24'd0, d[8*k +: 8]};
    return r;
  endfunction

  typedef struct { int id; bit err; bit to; } exp_t;
  exp_t sb[$];
  int   grants[$];
  int   mlast = NR - 1, cyc = 0, gcyc = 0, cur_id = 0, rst_cnt = 0, en_cnt = 0, n_resp = 0;
  bit   outstanding = 1'b0, prev_en = 1'b0, prev_done = 1'b0, to_en;
  logic [31:0] cur_dims;

`ifdef MATMUL_SCHED_TIMEOUT_EN
  initial to_en = 1'b1;
`else
  initial to_en = 1'b0;
`endif

  // Monitor: predicts grants from the round-robin rule and checks every response.
  always @(negedge clk) begin
    logic [NR-1:0] er;
    int c, gid;
    exp_t e;
    #4;
    if (reset) begin
      sb.delete(); outstanding = 1'b0; mlast = NR - 1;
    end else begin
      cyc++;
      if (resp_valid_o) n_resp++;
      if (!outstanding) begin
        er = '0; gid = 0;
        for (int k = 1; k <= NR; k++) begin
          c = (mlast + k) % NR;
          if (er == '0 && req_valid[c]) begin er[c] = 1'b1; gid = c; end
        end
        chk("idle_quiet", {busy_o, resp_valid_o, mm_enable_o, mm_reset_o}, 4'b0);
        if (er != '0 || req_ready_o != '0) chk("grant", req_ready_o, er);
        if (er != '0) begin
          cur_id = gid; cur_dims = req_dims[gid*JW +: JW];
          sb.push_back('{gid, bad(cur_dims) || (stuck && to_en), stuck && to_en && !bad(cur_dims)});
          outstanding = 1'b1; gcyc = cyc; rst_cnt = 0; en_cnt = 0;
          mrun = (mrun_force > 0) ? mrun_force : int'($urandom_range(1, 6));
          grants.push_back(gid);
        end
      end else begin
        chk("owner", {busy_o, mm_owner_o}, {1'b1, 2'(cur_id)});
        if (mm_reset_o) begin
          if (rst_cnt == 0) begin
            chk("clr_cyc", cyc - gcyc, 2);
            chk("cfg", mm_cfg_o, exp_cfg(cur_dims));
          end
          rst_cnt++;
        end
        if (mm_enable_o) en_cnt++;
        if (resp_valid_o) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL resp_unexpected: got id %0d want none", resp_id_o);
          end else begin
            e = sb.pop_front();
            chk("resp_id", resp_id_o, e.id);
            chk("resp_err", resp_err_o, e.err);
            if (e.to) chk("abort", {rst_cnt, en_cnt}, {32'd2, 32'd16});
            else if (e.err) begin
              chk("rej_lat", cyc - gcyc, 2);
              chk("rej_quiet", {rst_cnt, en_cnt}, 64'd0);
            end else chk("done_seq", {rst_cnt == 1, prev_en, prev_done, mm_enable_o}, 4'b1110);
            mlast = e.id;
          end
          outstanding = 1'b0;
        end
      end
      prev_en = mm_enable_o; prev_done = mm_done;
    end
  end

  // Stimulus: requests are held until the cycle after they were accepted.
  logic [NR-1:0] acc = '0;
  bit rnd_on = 1'b0, keep_all = 1'b0;

  function automatic logic [7:0] rdim();
    return ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (acc[i] && !keep_all) req_valid[i] = 1'b0;
    if (rnd_on) for (int i = 0; i < NR; i++) begin
      if (!req_valid[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          req_dims[i*JW +: JW] = {rdim(), rdim(), rdim(), rdim()};
          req_valid[i] = 1'b1;
        end
      end else if ($urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
    end
    #1 acc = req_ready_o;
  endtask

  task automatic post(input int i, input int wa, input int ha, input int wb, input int hb);
    req_dims[i*JW +: JW] = {8'(hb), 8'(wb), 8'(ha), 8'(wa)};
    req_valid[i] = 1'b1;
    #1 acc = req_ready_o;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((req_valid != '0 || outstanding) && b < 600) begin tick(); b++; end
    if (b >= 600) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got busy after %0d cycles want idle", b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; req_valid = '0; acc = '0;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    int b, r0;
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", {req_ready_o, resp_valid_o, resp_err_o, resp_id_o, busy_o, mm_owner_o,
                    mm_reset_o, mm_enable_o}, 0);
    chk("rst_cfg", mm_cfg_o, 0);
    req_valid = '0;
    @(negedge clk); reset = 1'b0;

    post(0, 2, 2, 2, 2);
    drain();

    do_reset();
    grants.delete();
    for (int i = 0; i < NR; i++) req_dims[i*JW +: JW] = {8'd2, 8'd2, 8'd2, 8'd2};
    req_valid = 4'hF; keep_all = 1'b1;
    b = 0;
    while (grants.size() < 5 && b < 300) begin tick(); b++; end
    keep_all = 1'b0; req_valid = '0; acc = '0;
    drain();
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], i % NR);

    post(1, 4, 4, 4, 4); drain();
    post(2, 2, 0, 2, 2); drain();
    post(3, 3, 1, 1, 1); drain();
    post(0, 2, 5, 2, 8); drain();
    post(1, 2, 6, 2, 8); drain();
    post(2, 4, 1, 1, 5); drain();

    rnd_on = 1'b1;
    repeat (400) tick();
    rnd_on = 1'b0;
    drain();

    do_reset();
    mrun_force = 20;
    post(1, 2, 2, 2, 2);
    b = 0;
    while (!(mm_enable_o && !mm_done) && b < 20) begin tick(); b++; end
    chk("reach_run", b < 20, 1'b1);
    @(negedge clk); reset = 1'b1; req_valid = '0; acc = '0;
    #1;
    chk("async_rst", {req_ready_o, resp_valid_o, resp_err_o, resp_id_o, busy_o, mm_owner_o,
                      mm_reset_o, mm_enable_o}, 0);
    chk("async_cfg", mm_cfg_o, 0);
    @(negedge clk); reset = 1'b0; mrun_force = 0;
    grants.delete();
    post(2, 2, 2, 2, 2);
    drain();
    chk("post_rst_grant", (grants.size() > 0) ? grants[0] : -1, 2);

    stuck = 1'b1;
    r0 = n_resp;
    post(0, 2, 2, 2, 2);
`ifdef MATMUL_SCHED_TIMEOUT_EN
    drain();
    chk("timeout_resp", n_resp - r0, 1);
    stuck = 1'b0;
`else
    repeat (60) tick();
    chk("hang", {outstanding, busy_o, mm_enable_o, n_resp == r0}, 4'b1111);
    stuck = 1'b0;
    do_reset();
`endif
    post(3, 2, 2, 2, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
